// File: rtl/div_pipe_sv.sv
// Pipelined restoring integer divider: per-operation signed/unsigned mode,
// RISC-V divide-by-zero / overflow results, tag sideband, whole-pipeline stall.
module div_pipe_sv #(
    parameter int DATA_W          = 32,
    parameter int OPERS_PER_STAGE = 8,
    parameter int TAG_W           = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_signed,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero,
    output logic              overflow,
    output logic [TAG_W-1:0]  out_tag
);
    localparam int S = DATA_W / OPERS_PER_STAGE;
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    // Stage 0 holds the converted operands; stages 1..S hold the partial
    // remainder (rem) and the dividend bits being shifted into quotient bits (quo).
    logic              vld_q  [0:S];
    logic [TAG_W-1:0]  tag_q  [0:S];
    logic              qneg_q [0:S];
    logic              rneg_q [0:S];
    logic              dbz_q  [0:S];
    logic              ovf_q  [0:S];
    logic [DATA_W-1:0] dvs_q  [0:S];
    logic [DATA_W:0]   rem_q  [0:S];
    logic [DATA_W-1:0] quo_q  [0:S];

    logic [DATA_W:0]   rem_d  [0:S];
    logic [DATA_W-1:0] quo_d  [0:S];
    logic [DATA_W-1:0] dvs_d;
    logic              qneg_d, rneg_d, dbz_d, ovf_d, a_neg, b_neg;
    logic              adv;

    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high. The whole pipeline advances together whenever the output slot is
    // empty or being taken, so in_ready never depends on in_valid.
    assign adv       = !vld_q[S] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[S];

    function automatic logic [2*DATA_W:0] div_iter(input logic [DATA_W:0]   rem,
                                                  input logic [DATA_W-1:0] quo,
                                                  input logic [DATA_W-1:0] dvs);
        logic [DATA_W:0]   r;
        logic [DATA_W-1:0] q;
        r = rem;
        q = quo;
        for (int i = 0; i < OPERS_PER_STAGE; i++) begin
            r = {r[DATA_W-1:0], q[DATA_W-1]};
            q = {q[DATA_W-2:0], 1'b0};
            if (r >= {1'b0, dvs}) begin
                r    = r - {1'b0, dvs};
                q[0] = 1'b1;
            end
        end
        return {r, q};
    endfunction

    always_comb begin
        a_neg    = in_signed & dividend[DATA_W-1];
        b_neg    = in_signed & divisor[DATA_W-1];
        qneg_d   = a_neg ^ b_neg;
        rneg_d   = a_neg;
        dbz_d    = (divisor == '0);
        ovf_d    = in_signed && (dividend == MOST_NEG) && (divisor == '1);
        dvs_d    = b_neg ? (DATA_W'(0) - divisor) : divisor;
        rem_d[0] = '0;
        quo_d[0] = a_neg ? (DATA_W'(0) - dividend) : dividend;
        for (int s = 1; s <= S; s++) begin
            {rem_d[s], quo_d[s]} = div_iter(rem_q[s-1], quo_q[s-1], dvs_q[s-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= S; s++) begin
                vld_q[s]  <= 1'b0;
                tag_q[s]  <= '0;
                qneg_q[s] <= 1'b0;
                rneg_q[s] <= 1'b0;
                dbz_q[s]  <= 1'b0;
                ovf_q[s]  <= 1'b0;
                dvs_q[s]  <= '0;
                rem_q[s]  <= '0;
                quo_q[s]  <= '0;
            end
        end else if (adv) begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                tag_q[0]  <= in_tag;
                qneg_q[0] <= qneg_d;
                rneg_q[0] <= rneg_d;
                dbz_q[0]  <= dbz_d;
                ovf_q[0]  <= ovf_d;
                dvs_q[0]  <= dvs_d;
                rem_q[0]  <= rem_d[0];
                quo_q[0]  <= quo_d[0];
            end
            for (int s = 1; s <= S; s++) begin
                vld_q[s]  <= vld_q[s-1];
                tag_q[s]  <= tag_q[s-1];
                qneg_q[s] <= qneg_q[s-1];
                rneg_q[s] <= rneg_q[s-1];
                dbz_q[s]  <= dbz_q[s-1];
                ovf_q[s]  <= ovf_q[s-1];
                dvs_q[s]  <= dvs_q[s-1];
                rem_q[s]  <= rem_d[s];
                quo_q[s]  <= quo_d[s];
            end
        end
    end

    // A zero divisor leaves |dividend| in the remainder, so the normal sign fix
    // restores the original dividend; only the quotient needs forcing.
    assign quotient    = dbz_q[S] ? '1 :
                         (qneg_q[S] ? (DATA_W'(0) - quo_q[S]) : quo_q[S]);
    assign remainder   = rneg_q[S] ? (DATA_W'(0) - rem_q[S][DATA_W-1:0])
                                   : rem_q[S][DATA_W-1:0];
    assign div_by_zero = dbz_q[S];
    assign overflow    = ovf_q[S];
    assign out_tag     = tag_q[S];
endmodule
